// File: rtl/ifetch_decode.sv
// Fetch/decode front end: owns the PC, fetches over valid/ready,
// one-hot decodes each word and picks the next PC when execute is done.
module ifetch_decode #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] decoded_instr,
  output logic        instr_valid,
  output logic        illegal_instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] rs_data
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC
  } state_t;

  state_t      state, state_nx;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic [31:0] dec_nx;
  logic        ill_nx;
  logic [5:0]  op;
  logic [5:0]  fn;

  assign op = imem_rsp_data[31:26];
  assign fn = imem_rsp_data[5:0];

  // Held low during reset so no request escapes before release
  assign imem_req_valid = (state == S_FETCH) & ~rst;
  assign imem_addr      = pc;
  assign pc_plus4       = pc + 32'd4;
  assign br_off         = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    unique case (npc_sel)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = rs_data & ~32'h3;
      2'b10: next_pc = pc_plus4 + br_off;
      2'b11: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    dec_nx = '0;
    ill_nx = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: dec_nx[0]  = 1'b1;
          6'h21: dec_nx[1]  = 1'b1;
          6'h22: dec_nx[2]  = 1'b1;
          6'h23: dec_nx[3]  = 1'b1;
          6'h24: dec_nx[4]  = 1'b1;
          6'h25: dec_nx[5]  = 1'b1;
          6'h26: dec_nx[6]  = 1'b1;
          6'h27: dec_nx[7]  = 1'b1;
          6'h2A: dec_nx[8]  = 1'b1;
          6'h2B: dec_nx[9]  = 1'b1;
          6'h00: dec_nx[10] = 1'b1;
          6'h02: dec_nx[11] = 1'b1;
          6'h03: dec_nx[12] = 1'b1;
          6'h04: dec_nx[13] = 1'b1;
          6'h06: dec_nx[14] = 1'b1;
          6'h07: dec_nx[15] = 1'b1;
          6'h08: dec_nx[16] = 1'b1;
          default: ill_nx = 1'b1;
        endcase
      end
      6'h08: dec_nx[17] = 1'b1;
      6'h09: dec_nx[18] = 1'b1;
      6'h0C: dec_nx[19] = 1'b1;
      6'h0D: dec_nx[20] = 1'b1;
      6'h0E: dec_nx[21] = 1'b1;
      6'h0F: dec_nx[22] = 1'b1;
      6'h23: dec_nx[23] = 1'b1;
      6'h2B: dec_nx[24] = 1'b1;
      6'h04: dec_nx[25] = 1'b1;
      6'h05: dec_nx[26] = 1'b1;
      6'h0A: dec_nx[27] = 1'b1;
      6'h0B: dec_nx[28] = 1'b1;
      6'h02: dec_nx[29] = 1'b1;
      6'h03: dec_nx[30] = 1'b1;
      default: ill_nx = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: if (imem_req_ready) state_nx = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_nx = S_EXEC;
      S_EXEC:  if (exec_done)      state_nx = S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FETCH;
      pc            <= PC_RESET;
      instr         <= '0;
      decoded_instr <= '0;
      instr_valid   <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT && imem_rsp_valid) begin
        instr         <= imem_rsp_data;
        decoded_instr <= dec_nx;
        illegal_instr <= ill_nx;
        instr_valid   <= 1'b1;
      end
      if (state == S_EXEC && exec_done) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_decode.sv
// Scoreboard bench for ifetch_decode: drives fetch/exec traffic,
// queues expected decode results and compares them in EXEC.
module tb_ifetch_decode;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] decoded_instr;
  logic        instr_valid;
  logic        illegal_instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic [1:0]  npc_sel;
  logic [31:0] rs_data;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] dec;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_decode #(.PC_RESET(PC_RST)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instr(instr),
    .decoded_instr(decoded_instr),
    .instr_valid(instr_valid),
    .illegal_instr(illegal_instr),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .exec_done(exec_done),
    .npc_sel(npc_sel),
    .rs_data(rs_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid === 1'b1) return;
      @(negedge clk);
    end
    chk("req_timeout", {31'd0, imem_req_valid}, 32'd1);
  endtask

  task automatic do_instr(input logic [31:0] w, input int bit_i,
                          input logic [1:0] sel, input logic [31:0] rs,
                          input logic [31:0] nxt, input int stall,
                          input int dly, input bit spur);
    exp_t e;
    exp_t g;
    wait_req();
    chk("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, exp_pc);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_reqv", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      exec_done = spur;
      @(negedge clk);
      exec_done = 1'b0;
      chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = w;
    e.ins = w;
    e.dec = (bit_i < 0) ? 32'd0 : (32'd1 << bit_i);
    e.ill = (bit_i < 0);
    e.pc  = exp_pc;
    sb.push_back(e);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~w;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
    end
    chk("exec_ivalid", {31'd0, instr_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("instr", instr, g.ins);
      chk("decoded", decoded_instr, g.dec);
      chk("illegal", {31'd0, illegal_instr}, {31'd0, g.ill});
      chk("pc", pc, g.pc);
      chk("pc_plus4", pc_plus4, g.pc + 32'd4);
    end
    exec_done = 1'b1;
    npc_sel   = sel;
    rs_data   = rs;
    @(negedge clk);
    exec_done = 1'b0;
    chk("post_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("next_pc", pc, nxt);
    exp_pc = nxt;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    exec_done      = 1'b0;
    npc_sel        = 2'b00;
    rs_data        = '0;
    exp_pc         = PC_RST;
    repeat (2) @(negedge clk);
    chk("rst_reqv", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, PC_RST);
    chk("rst_instr", instr, 32'd0);
    chk("rst_dec", decoded_instr, 32'd0);
    chk("rst_ill", {31'd0, illegal_instr}, 32'd0);
    imem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("first_reqv", {31'd0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h0040_0000);

    do_instr(32'h2008_0005, 17, 2'b00, 0, 32'h0040_0004, 0, 0, 0);
    do_instr(32'h0109_5020,  0, 2'b00, 0, 32'h0040_0008, 0, 1, 0);
    do_instr(32'h8D09_0000, 23, 2'b00, 0, 32'h0040_000C, 1, 0, 0);
    do_instr(32'hAD09_0004, 24, 2'b00, 0, 32'h0040_0010, 0, 0, 0);
    do_instr(32'h1109_FFFE, 25, 2'b10, 0, 32'h0040_000C, 0, 0, 0);
    do_instr(32'h0100_0008, 16, 2'b01, 32'h0040_0020,
             32'h0040_0020, 0, 0, 0);
    do_instr(32'h0C10_0040, 30, 2'b11, 0, 32'h0040_0100, 0, 0, 0);
    do_instr(32'h0100_0008, 16, 2'b01, 32'h0040_0203,
             32'h0040_0200, 0, 0, 0);
    do_instr(32'hFC00_0000, -1, 2'b00, 0, 32'h0040_0204, 3, 4, 1);
    do_instr(32'h0008_4083, 12, 2'b00, 0, 32'h0040_0208, 0, 0, 0);
    do_instr(32'h3508_FFFF, 20, 2'b00, 0, 32'h0040_020C, 0, 0, 0);

    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_reqv", {31'd0, imem_req_valid}, 32'd0);
    chk("mid_rst_pc", pc, PC_RST);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2008_0005;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("late_rsp_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("late_rsp_instr", instr, 32'd0);
    chk("late_rsp_reqv", {31'd0, imem_req_valid}, 32'd1);
    exp_pc = PC_RST;

    do_instr(32'h0100_0008, 16, 2'b01, 32'hFFFF_FFFC,
             32'hFFFF_FFFC, 0, 0, 0);
    do_instr(32'h2008_0005, 17, 2'b00, 0, 32'h0000_0000, 0, 0, 0);
    do_instr(32'h0800_0010, 29, 2'b11, 0, 32'h0000_0040, 0, 0, 0);

    if (sb.size() != 0) chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=done");
    $fatal(1);
  end

endmodule
